// File: rtl/cache_mm_pkg.sv
// Shared definitions for the cache/main-memory request front-end.
//   ADDR_W / DATA_W : address and data widths of the controller (32 x 16-bit).
//   req_t           : one queued request {write, addr, data}.
//   state_t         : issue FSM states.
package cache_mm_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/req_fifo.sv
// Parameterised synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i, wdata_i: write one entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   rdata_o        : current head entry, valid whenever !empty_o
//   full_o, empty_o, count_o : occupancy status
module req_fifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cache_req_queue.sv
// Request front-end for the cache/main-memory controller.
// Buffers valid/ready requests in a FIFO and replays them one at a time onto
// the controller's level-sensitive enables, returning read data as a pulse.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready/req_write/req_addr/req_data : upstream request port
//   enable_write/enable_read/addr_mm/data_in        : controller drive (registered)
//   ctrl_data_out                    : controller read data
//   rsp_valid/rsp_addr/rsp_data      : one-cycle read response
module cache_req_queue
  import cache_mm_pkg::*;
#(
  parameter int ADDR_W = cache_mm_pkg::ADDR_W,
  parameter int DATA_W = cache_mm_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              enable_write,
  output logic              enable_read,
  output logic [ADDR_W-1:0] addr_mm,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ctrl_data_out,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data
);

  localparam int REQ_W  = 1 + ADDR_W + DATA_W;
  localparam int FCNT_W = $clog2(DEPTH) + 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [REQ_W-1:0]  head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [FCNT_W-1:0] fifo_count;
  logic              unused_fifo_full;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              we_q, we_d, re_q, re_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Ready is not-full only; a pop in the same cycle does not open a slot.
  assign req_ready = (fifo_count != FCNT_W'(DEPTH));
  assign unused_fifo_full = fifo_full;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid && req_ready),
    .pop_i   (fifo_pop),
    .wdata_i ({req_write, req_addr, req_data}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_write = head[REQ_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_data  = head[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          din_d    = head_data;
          wait_d   = WAIT_W'(RD_LAT - 1);
          state_d  = head_write ? WR : RD;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        // Sample on the last cycle enable_read is held; the pulse follows.
        if (wait_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_data_d  = ctrl_data_out;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Enables are registered copies of the next state, so they are low in
    // IDLE and can never both be high.
    we_d = (state_d == WR);
    re_d = (state_d == RD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      re_q        <= re_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign enable_write = we_q;
  assign enable_read  = re_q;
  assign addr_mm      = addr_q;
  assign data_in      = din_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_addr     = rsp_addr_q;
  assign rsp_data     = rsp_data_q;

endmodule
